// File: rtl/sha_core_job_loader.sv
// Assembles an 11-word mining job (midstate a..h, tail w1..w3) into a shadow buffer and
// hands it to a SHA core with a one-cycle newblock pulse. Build option: LOADER_BYTESWAP_EN.
module sha_core_job_loader #(
  parameter int COUNT_W      = 8,
  parameter bit ABORT_ON_NEW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_word,
  input  logic               in_last,
  input  logic               core_done,
  output logic               out_valid,
  output logic               out_newblock,
  output logic [255:0]       out_hashstate,
  output logic [31:0]        out_w1,
  output logic [31:0]        out_w2,
  output logic [31:0]        out_w3,
  output logic               busy,
  output logic               frame_err,
  output logic [COUNT_W-1:0] jobs_issued
);

  // state    | meaning
  // ST_IDLE  | no job presented to the core; waits for a full shadow
  // ST_ISSUE | first cycle of a new job, newblock asserted
  // ST_RUN   | core working on the active job, waits for core_done
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]         r_cnt;
  logic [31:0]        r_shadow [11];
  logic               r_shadow_full;
  logic               r_in_ready;
  logic               r_frame_err;
  logic [255:0]       r_hash;
  logic [31:0]        r_w1;
  logic [31:0]        r_w2;
  logic [31:0]        r_w3;
  logic [COUNT_W-1:0] r_jobs;

  logic        w_hs;
  logic        w_word_end;
  logic        w_bad;
  logic        w_good_last;
  logic        w_load;
  logic [31:0] w_word;

`ifdef LOADER_BYTESWAP_EN
  assign w_word = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
  assign w_word = in_word;
`endif

  assign w_hs        = in_valid & r_in_ready;
  assign w_word_end  = (r_cnt == 4'd10);
  assign w_bad       = w_hs & (in_last != w_word_end);
  assign w_good_last = w_hs & in_last & w_word_end;

  // Framing: a bad word is dropped and the partial job is abandoned by rewinding the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= 4'd0;
      r_shadow_full <= 1'b0;
      r_in_ready    <= 1'b1;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      if (w_hs) begin
        if (w_bad || w_word_end) begin
          r_cnt <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      if (w_good_last) begin
        r_shadow_full <= 1'b1;
        r_in_ready    <= 1'b0;
      end else if (w_load) begin
        r_shadow_full <= 1'b0;
        r_in_ready    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_bad) begin
      r_shadow[r_cnt] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_shadow_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_shadow_full && (core_done || ABORT_ON_NEW)) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (core_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output data only moves on a transfer, so the last job stays visible in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hash <= '0;
      r_w1   <= '0;
      r_w2   <= '0;
      r_w3   <= '0;
    end else if (w_load) begin
      r_hash <= {r_shadow[0], r_shadow[1], r_shadow[2], r_shadow[3],
                 r_shadow[4], r_shadow[5], r_shadow[6], r_shadow[7]};
      r_w1   <= r_shadow[8];
      r_w2   <= r_shadow[9];
      r_w3   <= r_shadow[10];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_jobs <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_jobs <= r_jobs + 1'b1;
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = (r_state != ST_IDLE);
  assign out_newblock  = (r_state == ST_ISSUE);
  assign busy          = (r_state != ST_IDLE);
  assign frame_err     = r_frame_err;
  assign out_hashstate = r_hash;
  assign out_w1        = r_w1;
  assign out_w2        = r_w2;
  assign out_w3        = r_w3;
  assign jobs_issued   = r_jobs;

endmodule

// File: tb/tb_sha_core_job_loader.sv
// Bench for sha_core_job_loader: directed scenarios plus random job streams against a
// queue-based model of accepted jobs; follows LOADER_BYTESWAP_EN if defined.
module tb_sha_core_job_loader;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_word;
  logic          in_last;
  logic          core_done;
  logic          out_valid;
  logic          out_newblock;
  logic [255:0]  out_hashstate;
  logic [31:0]   out_w1;
  logic [31:0]   out_w2;
  logic [31:0]   out_w3;
  logic          busy;
  logic          frame_err;
  logic [CW-1:0] jobs_issued;

  sha_core_job_loader #(.COUNT_W(CW), .ABORT_ON_NEW(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .in_last(in_last), .core_done(core_done), .out_valid(out_valid),
    .out_newblock(out_newblock), .out_hashstate(out_hashstate), .out_w1(out_w1),
    .out_w2(out_w2), .out_w3(out_w3), .busy(busy), .frame_err(frame_err),
    .jobs_issued(jobs_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] hs;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
  } job_t;

  job_t        exp_q[$];
  job_t        mon_j;
  job_t        last_j;
  logic [31:0] jw [11];
  int          n_checks = 0;
  int          n_err = 0;
  int          exp_issued = 0;
  logic        prev_nb = 1'b0;
  bit          stop_core;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] host2core(input logic [31:0] w);
`ifdef LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic job_t job_of_words();
    job_t j;
    for (int i = 0; i < 8; i++) j.hs[255-32*i -: 32] = host2core(jw[i]);
    j.w1 = host2core(jw[8]);
    j.w2 = host2core(jw[9]);
    j.w3 = host2core(jw[10]);
    return j;
  endfunction

  // Issue monitor: every newblock must present the oldest accepted job.
  always @(negedge clk) begin
    if (rst) begin
      prev_nb = 1'b0;
    end else begin
      if (prev_nb) begin
        check("nb_width", out_newblock, 1'b0);
        check("jobs_issued", jobs_issued, exp_issued[CW-1:0]);
      end
      if (out_newblock) begin
        if (exp_q.size() == 0) begin
          check("unexp_issue", out_newblock, 1'b0);
        end else begin
          mon_j = exp_q.pop_front();
          check("hashstate", out_hashstate, mon_j.hs);
          check("w1", out_w1, mon_j.w1);
          check("w2", out_w2, mon_j.w2);
          check("w3", out_w3, mon_j.w3);
          check("valid_at_issue", out_valid, 1'b1);
          exp_issued++;
        end
      end
      prev_nb = out_newblock;
    end
  end

  task automatic send_word(input logic [31:0] w, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_job();
    last_j = job_of_words();
    exp_q.push_back(last_j);
    for (int i = 0; i < 11; i++) send_word(jw[i], i == 10);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 11; i++) jw[i] = $urandom;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!out_newblock && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("issue_seen", out_newblock, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_issued = 0;
    rst = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_newblock", out_newblock, 1'b0);
    check("rst_hash", out_hashstate, 256'd0);
    check("rst_w", {out_w1, out_w2, out_w3}, 96'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_jobs", jobs_issued, '0);
    check("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] vec [11];
    rst = 1'b1; in_valid = 1'b0; in_word = '0; in_last = 1'b0; core_done = 1'b0;
    vec = '{32'h9524c593, 32'h05c56713, 32'h16e669ba, 32'h2d2810a0, 32'h07e86e37,
            32'h2f56a9da, 32'hcd5bce69, 32'h7a78da2d, 32'hf1fc122b, 32'hc7f5d74d,
            32'hf2b9441a};
    @(negedge clk);
    do_reset();

    // Known vector, latency and single-cycle newblock
    jw = vec;
    send_job();
    check("lat_no_nb_yet", out_newblock, 1'b0);
    @(negedge clk);
    check("lat_nb", out_newblock, 1'b1);
    @(negedge clk);
    check("job1_count", jobs_issued, 8'd1);
    check("job1_run_valid", out_valid, 1'b1);

    // Back-to-back: second job queued in RUN, core_done reloads without dropping valid
    rand_words();
    send_job();
    check("b2b_ready_low", in_ready, 1'b0);
    pulse_done();
    check("b2b_nb", out_newblock, 1'b1);
    check("b2b_valid", out_valid, 1'b1);
    @(negedge clk);
    check("b2b_valid2", out_valid, 1'b1);
    check("b2b_count", jobs_issued, 8'd2);

    // Early in_last on 6th word
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    check("ferr_pulse", frame_err, 1'b1);
    @(negedge clk);
    check("ferr_once", frame_err, 1'b0);
    check("ferr_ready", in_ready, 1'b1);
    rand_words();
    send_job();
    pulse_done();
    check("after_ferr_nb", out_newblock, 1'b1);

    // Drain to IDLE, then two jobs with no core_done: third job stalls
    @(negedge clk);
    pulse_done();
    check("idle_valid", out_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_hold", out_hashstate, last_j.hs);
    rand_words();
    send_job();
    rand_words();
    send_job();
    check("stall_ready", in_ready, 1'b0);
    rand_words();
    in_valid = 1'b1; in_word = jw[0]; in_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stall_hold", in_ready, 1'b0);
    end
    pulse_done();
    check("stall_release", in_ready, 1'b1);
    send_job();

    // Reset in the middle of a frame
    @(negedge clk);
    pulse_done();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) send_word($urandom, 1'b0);
    do_reset();
    rand_words();
    send_job();
    wait_issue();

    // Random streams with random core timing and occasional framing faults
    stop_core = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          int mode;
          int cut;
          rand_words();
          mode = $urandom_range(0, 9);
          if (mode >= 2) begin
            send_job();
          end else begin
            cut = (mode == 0) ? $urandom_range(0, 9) : 10;
            for (int i = 0; i < cut; i++) send_word(jw[i], 1'b0);
            send_word(jw[cut], mode == 0);
            check("rand_ferr", frame_err, 1'b1);
          end
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        stop_core = 1'b1;
      end
      begin
        while (!stop_core) begin
          @(negedge clk);
          core_done = out_valid && !out_newblock && !core_done && ($urandom_range(0, 2) == 0);
        end
        core_done = 1'b0;
      end
    join
    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 2000) begin
        @(negedge clk);
        core_done = out_valid && !out_newblock && !core_done;
        n++;
      end
      core_done = 1'b0;
      check("drain", exp_q.size(), 0);
    end

`ifdef LOADER_BYTESWAP_EN
    repeat (3) @(negedge clk);
    if (out_valid) pulse_done();
    repeat (2) @(negedge clk);
    rand_words();
    jw[0] = 32'h93c52495;
    send_job();
    wait_issue();
    check("byteswap_a", out_hashstate[255:224], 32'h9524c593);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
